packet_fifo_reader: RTL and testbench
=====================================

PACKET_FIFO_READER -- requirements
Module: packet_fifo_reader

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have Avalon-ST sink ports: asi_data in 32; asi_valid in 1; asi_ready out 1; asi_startofpacket in 1; asi_endofpacket in 1.
REQ-004 SHALL have Avalon-MM slave ports for the HPS lightweight bridge: avs_address in 2 (word address); avs_read in 1; avs_readdata out 32; avs_write in 1; avs_writedata in 32.
REQ-005 SHALL have an Avalon-MM slave with fixed read latency 1, no waitrequest, and no readdatavalid.
REQ-006 SHALL have output irq, 1, high while at least one complete packet is stored.

Function
REQ-007 SHALL store data in a 256x32 word RAM with 9-bit write pointer wr_ptr, commit pointer pkt_start and read pointer rd_ptr, all wrapping modulo 256 on the low 8 bits.
REQ-008 SHALL hold lengths of committed packets in a 16-entry length FIFO; each entry is 9 bits, 1..256 words.
REQ-009 SHALL drive asi_ready = !len_fifo_full; data-RAM fullness never backpressures.
REQ-010 SHALL run a sink FSM with states IDLE, RECV and DROP.
REQ-011 SHALL, in IDLE, treat a beat without sop as ignored with no counter change; a beat with sop writes a word, sets wr_ptr+1, and enters RECV (or commits immediately if eop is also set).
REQ-012 SHALL, in RECV, write each accepted beat; on eop, push length = wr_ptr - pkt_start (including this beat) into the length FIFO, set pkt_start = new wr_ptr, and return to IDLE.
REQ-013 SHALL, when an accepted beat finds the data RAM full (wr_ptr - rd_ptr == 256), discard the word, roll wr_ptr back to pkt_start, and enter DROP; DROP discards beats until eop and then returns to IDLE.
REQ-014 SHALL, on sop in RECV or DROP, roll wr_ptr back to pkt_start, count one drop, and start the new packet as in IDLE.
REQ-015 SHALL increment drop_cnt (8-bit, saturating at 255) once per dropped packet for the cases in REQ-013 and REQ-014.
REQ-016 SHALL decode register reads as follows: addr 0 DATA; addr 1 STATUS = {avail, 6'b0, head_len[8:0], 7'b0, head_remaining[8:0]}; addr 2 LEVEL = {11'b0, pkt_count[4:0], 7'b0, used_words[8:0]}; addr 3 = {24'b0, drop_cnt}.
REQ-017 SHALL, on a DATA read with avail=1, return RAM[rd_ptr] the next cycle, increment rd_ptr, and decrement head_remaining; on reaching 0, pop the length FIFO and load the next head length.
REQ-018 SHALL, on a DATA read with avail=0, return 0 with no state change.
REQ-019 SHALL, on a write to addr 3 with bit0 set (FLUSH_HEAD), advance rd_ptr by head_remaining and pop the head packet; no effect if avail=0.
REQ-020 SHALL, on a write to addr 3 with bit1 set (CLEAR), zero all pointers, the length FIFO and drop_cnt, and force the FSM to IDLE; bit1 takes priority over bit0 and over a same-cycle sink beat.
REQ-021 SHALL process a same-cycle commit and head pop correctly; pkt_count is unchanged when both occur.
REQ-022 SHALL ignore writes to addresses 0-2 and ignore avs_read and avs_write asserted together (write wins).

Reset
REQ-023 SHALL, with reset high, zero all pointers, pkt_count, drop_cnt, avs_readdata and irq, set the FSM to IDLE, and set asi_ready=0; asi_ready=1 the first cycle after reset release.
REQ-024 SHALL, on reset mid-packet, discard the in-progress packet without counting it as a drop.

Verification
REQ-025 SHALL cover a single-beat packet: sop+eop with data 0xA5A5_0001 -> STATUS avail=1, head_len=1; DATA read returns 0xA5A5_0001; then avail=0 and irq=0.
REQ-026 SHALL cover three 4-word packets: three DATA reads then a STATUS read -> head_remaining=1, pkt_count=3, used_words=9.
REQ-027 SHALL cover a 300-word packet -> drop_cnt=1, pkt_count=0, used_words=0; a following 2-word packet is then read back intact.
REQ-028 SHALL cover a 3-word packet with a sop beat arriving mid-packet, then a 2-word packet -> drop_cnt=1; only the 2-word packet is readable.
REQ-029 SHALL cover 16 committed packets -> asi_ready=0; one full head drain or FLUSH_HEAD -> asi_ready=1 the next cycle.
REQ-030 SHALL cover CLEAR asserted during a RECV beat -> LEVEL=0, drop_cnt=0; the next sop-less beat is ignored.

Source files
------------

// File: rtl/packet_fifo_reader_if.sv
// Bus bundle for packet_fifo_reader: Avalon-ST sink, Avalon-MM register slave and irq.
interface packet_fifo_reader_if;
  logic [31:0] asi_data;
  logic        asi_valid;
  logic        asi_ready;
  logic        asi_startofpacket;
  logic        asi_endofpacket;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;

  modport master (
    output asi_data, asi_valid, asi_startofpacket, asi_endofpacket,
    output avs_address, avs_read, avs_write, avs_writedata,
    input  asi_ready, avs_readdata, irq
  );

  modport slave (
    input  asi_data, asi_valid, asi_startofpacket, asi_endofpacket,
    input  avs_address, avs_read, avs_write, avs_writedata,
    output asi_ready, avs_readdata, irq
  );
endinterface

// File: rtl/packet_fifo_reader.sv
// Packet buffer: stores whole Avalon-ST packets in a 256-word RAM and lets the HPS
// read them out word by word through a four-register Avalon-MM slave.
module packet_fifo_reader (
  input  logic                 clk,
  input  logic                 reset,
  packet_fifo_reader_if.slave  bus
);
  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned AW        = 8;
  localparam int unsigned PW        = 9;
  localparam int unsigned LEN_DEPTH = 16;
  localparam int unsigned LAW       = 4;
  localparam int unsigned CW        = 5;
  localparam int unsigned DCW       = 8;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t         state;
  logic [DW-1:0]  ram     [DEPTH];
  logic [PW-1:0]  len_mem [LEN_DEPTH];
  logic [PW-1:0]  wr_ptr, pkt_start, rd_ptr, head_consumed;
  logic [LAW-1:0] len_wr_idx, len_rd_idx;
  logic [CW-1:0]  pkt_count, count_next;
  logic [DCW-1:0] drop_cnt;

  logic           sop, eop, accept, abort, wants_write, ram_full, do_write, overflow, push;
  logic [PW-1:0]  base, wr_next, commit_len, head_len, head_remaining, used_words;
  logic           avail, data_read, reg_read, reg_write, clear, flush, last_read, pop;
  logic [1:0]     drop_inc;
  logic [DCW:0]   drop_sum;
  logic [DW-1:0]  rd_mux;
  logic           unused_wdata;

  assign unused_wdata = ^bus.avs_writedata[DW-1:2];

  // Register-side decode; a simultaneous write suppresses the read.
  always_comb begin
    avail          = (pkt_count != '0);
    head_len       = avail ? len_mem[len_rd_idx] : '0;
    head_remaining = head_len - head_consumed;
    used_words     = wr_ptr - rd_ptr;
    reg_read       = bus.avs_read && !bus.avs_write;
    data_read      = reg_read && (bus.avs_address == 2'd0);
    reg_write      = bus.avs_write && (bus.avs_address == 2'd3);
    clear          = reg_write && bus.avs_writedata[1];
    flush          = reg_write && bus.avs_writedata[0] && !clear && avail;
    last_read      = data_read && avail && (head_remaining == PW'(1));
    pop            = flush || last_read;
    unique case (bus.avs_address)
      2'd0:    rd_mux = avail ? ram[rd_ptr[AW-1:0]] : '0;
      2'd1:    rd_mux = {avail, 6'b0, head_len, 7'b0, head_remaining};
      2'd2:    rd_mux = {11'b0, pkt_count, 7'b0, used_words};
      default: rd_mux = {24'b0, drop_cnt};
    endcase
  end

  // Sink-side decode; a sop beat always restarts from the commit pointer.
  always_comb begin
    sop         = bus.asi_startofpacket;
    eop         = bus.asi_endofpacket;
    accept      = bus.asi_valid && bus.asi_ready && !clear;
    abort       = accept && sop && (state != IDLE);
    wants_write = accept && (sop || (state == RECV));
    base        = sop ? pkt_start : wr_ptr;
    ram_full    = ((base - rd_ptr) == PW'(DEPTH));
    do_write    = wants_write && !ram_full;
    overflow    = wants_write && ram_full;
    wr_next     = base + PW'(1);
    commit_len  = wr_next - pkt_start;
    push        = do_write && eop;
    count_next  = pkt_count + CW'(push) - CW'(pop);
    drop_inc    = 2'(abort) + 2'(overflow);
    drop_sum    = (DCW+1)'(drop_cnt) + (DCW+1)'(drop_inc);
  end

  // Storage arrays carry no reset; pointers alone define their contents.
  always_ff @(posedge clk) begin
    if (!reset && do_write) ram[base[AW-1:0]] <= bus.asi_data;
    if (!reset && push)     len_mem[len_wr_idx] <= commit_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      pkt_start        <= '0;
      rd_ptr           <= '0;
      head_consumed    <= '0;
      len_wr_idx       <= '0;
      len_rd_idx       <= '0;
      pkt_count        <= '0;
      drop_cnt         <= '0;
      bus.avs_readdata <= '0;
      bus.irq          <= 1'b0;
      bus.asi_ready    <= 1'b0;
    end else if (clear) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      pkt_start        <= '0;
      rd_ptr           <= '0;
      head_consumed    <= '0;
      len_wr_idx       <= '0;
      len_rd_idx       <= '0;
      pkt_count        <= '0;
      drop_cnt         <= '0;
      bus.irq          <= 1'b0;
      bus.asi_ready    <= 1'b1;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_next;
        if (eop) begin
          pkt_start  <= wr_next;
          len_wr_idx <= len_wr_idx + LAW'(1);
          state      <= IDLE;
        end else begin
          state      <= RECV;
        end
      end else if (overflow) begin
        wr_ptr <= pkt_start;
        state  <= eop ? IDLE : DROP;
      end else if (accept && (state == DROP) && eop) begin
        state  <= IDLE;
      end

      if (abort || overflow)
        drop_cnt <= drop_sum[DCW] ? {DCW{1'b1}} : drop_sum[DCW-1:0];

      if (data_read && avail) begin
        rd_ptr        <= rd_ptr + PW'(1);
        head_consumed <= last_read ? '0 : head_consumed + PW'(1);
      end else if (flush) begin
        rd_ptr        <= rd_ptr + head_remaining;
        head_consumed <= '0;
      end
      if (pop) len_rd_idx <= len_rd_idx + LAW'(1);

      pkt_count     <= count_next;
      bus.irq       <= (count_next != '0);
      bus.asi_ready <= (count_next != CW'(LEN_DEPTH));
      if (reg_read) bus.avs_readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_packet_fifo_reader.sv
// Self-checking bench for packet_fifo_reader: directed scenarios plus random traffic
// compared against a queue-based packet model.
module tb_packet_fifo_reader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  packet_fifo_reader_if bus();
  packet_fifo_reader dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: unread committed words, lengths of unread packets, in-progress packet.
  logic [31:0] words_q[$];
  logic [31:0] cur_q[$];
  int          len_q[$];
  int          consumed;
  bit          in_pkt, dropping, m_ready;
  int          drops;
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_wipe();
    words_q.delete(); cur_q.delete(); len_q.delete();
    consumed = 0; in_pkt = 0; dropping = 0; drops = 0;
  endfunction

  function automatic void inc_drop();
    if (drops < 255) drops++;
  endfunction

  function automatic void model_cycle(input bit v, input bit s, input bit e, input logic [31:0] d,
                                      input bit r, input bit w, input logic [1:0] a,
                                      input logic [31:0] wd);
    bit avail     = (len_q.size() != 0);
    int committed = words_q.size();
    bit acc       = v && m_ready;
    int head_len  = avail ? len_q[0] : 0;
    int head_rem  = avail ? len_q[0] - consumed : 0;
    if (w && a == 2'd3 && wd[1]) begin
      model_wipe();
    end else begin
      if (r && !w) begin
        case (a)
          2'd0:    exp_rd = avail ? words_q[0] : 32'h0;
          2'd1:    exp_rd = {avail, 6'b0, 9'(head_len), 7'b0, 9'(head_rem)};
          2'd2:    exp_rd = {11'b0, 5'(len_q.size()), 7'b0, 9'(committed + cur_q.size())};
          default: exp_rd = {24'b0, 8'(drops)};
        endcase
        if (a == 2'd0 && avail) begin
          void'(words_q.pop_front());
          consumed++;
          if (consumed == len_q[0]) begin void'(len_q.pop_front()); consumed = 0; end
        end
      end
      if (w && a == 2'd3 && wd[0] && avail) begin
        repeat (head_rem) void'(words_q.pop_front());
        void'(len_q.pop_front());
        consumed = 0;
      end
      if (acc) begin
        if (s) begin
          if (in_pkt || dropping) inc_drop();
          cur_q.delete(); in_pkt = 1; dropping = 0;
        end
        if (in_pkt) begin
          if (committed + cur_q.size() == 256) begin
            inc_drop(); cur_q.delete(); in_pkt = 0; dropping = !e;
          end else begin
            cur_q.push_back(d);
            if (e) begin
              foreach (cur_q[i]) words_q.push_back(cur_q[i]);
              len_q.push_back(cur_q.size());
              cur_q.delete(); in_pkt = 0;
            end
          end
        end else if (dropping && e) begin
          dropping = 0;
        end
      end
    end
    m_ready = (len_q.size() != 16);
  endfunction

  task automatic step(input bit v, input bit s, input bit e, input logic [31:0] d,
                      input bit r, input bit w, input logic [1:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata);
    bus.asi_valid = v; bus.asi_startofpacket = s; bus.asi_endofpacket = e; bus.asi_data = d;
    bus.avs_read = r; bus.avs_write = w; bus.avs_address = a; bus.avs_writedata = wd;
    model_cycle(v, s, e, d, r, w, a, wd);
    @(posedge clk); #1;
    rdata = bus.avs_readdata;
    if (r && !w) check("readdata", rdata, exp_rd);
    check("asi_ready", 32'(bus.asi_ready), 32'(m_ready));
    check("irq", 32'(bus.irq), 32'(len_q.size() != 0));
  endtask

  task automatic beat(input bit s, input bit e, input logic [31:0] d);
    logic [31:0] x;
    step(1'b1, s, e, d, 1'b0, 1'b0, 2'd0, 32'h0, x);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] x);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0, x);
  endtask

  task automatic wr3(input logic [31:0] wd);
    logic [31:0] x;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2'd3, wd, x);
  endtask

  task automatic idle();
    logic [31:0] x;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, x);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.asi_valid = 0; bus.asi_startofpacket = 0; bus.asi_endofpacket = 0; bus.asi_data = '0;
    bus.avs_read = 0; bus.avs_write = 0; bus.avs_address = '0; bus.avs_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.asi_ready), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_readdata", bus.avs_readdata, 32'd0);
    reset = 1'b0;
    model_wipe(); m_ready = 0; exp_rd = '0;
  endtask

  initial begin
    logic [31:0] x;
    bit v, s, e, r, w;
    logic [1:0] a;
    logic [31:0] wd;

    // Single-beat packet
    do_reset();
    idle();
    check("ready_after_rst", 32'(bus.asi_ready), 32'd1);
    beat(1, 1, 32'hA5A5_0001);
    rd(2'd1, x);
    check("sb_avail", 32'(x[31]), 32'd1);
    check("sb_head_len", 32'(x[24:16]), 32'd1);
    rd(2'd0, x);
    check("sb_data", x, 32'hA5A5_0001);
    rd(2'd1, x);
    check("sb_avail_after", 32'(x[31]), 32'd0);
    check("sb_irq_after", 32'(bus.irq), 32'd0);

    // Three 4-word packets, three reads
    wr3(32'h2);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) beat(i == 0, i == 3, 32'h1000 + 32'(p * 16 + i));
    repeat (3) rd(2'd0, x);
    rd(2'd1, x);
    check("p3_head_rem", 32'(x[8:0]), 32'd1);
    rd(2'd2, x);
    check("p3_pkt_count", 32'(x[20:16]), 32'd3);
    check("p3_used", 32'(x[8:0]), 32'd9);

    // Oversized packet, then a good one
    wr3(32'h2);
    for (int i = 0; i < 300; i++) beat(i == 0, i == 299, 32'(i));
    rd(2'd2, x);
    check("big_level", x, 32'd0);
    rd(2'd3, x);
    check("big_drops", x, 32'd1);
    beat(1, 0, 32'hC0DE_0000);
    beat(0, 1, 32'hC0DE_0001);
    rd(2'd0, x);
    check("big_next0", x, 32'hC0DE_0000);
    rd(2'd0, x);
    check("big_next1", x, 32'hC0DE_0001);

    // Sop mid-packet aborts the first packet
    wr3(32'h2);
    beat(1, 0, 32'hD0); beat(0, 0, 32'hD1); beat(0, 0, 32'hD2);
    beat(1, 0, 32'hE0); beat(0, 1, 32'hE1);
    rd(2'd3, x);
    check("abort_drops", x, 32'd1);
    rd(2'd2, x);
    check("abort_level", x, {11'b0, 5'd1, 7'b0, 9'd2});
    rd(2'd0, x);
    check("abort_d0", x, 32'hE0);
    rd(2'd0, x);
    check("abort_d1", x, 32'hE1);

    // Length FIFO full backpressure
    wr3(32'h2);
    for (int i = 0; i < 16; i++) beat(1, 1, 32'hF00 + 32'(i));
    check("full_ready", 32'(bus.asi_ready), 32'd0);
    beat(1, 1, 32'hBAD);
    rd(2'd2, x);
    check("full_count", 32'(x[20:16]), 32'd16);
    wr3(32'h1);
    check("flush_ready", 32'(bus.asi_ready), 32'd1);
    beat(1, 1, 32'hF10);
    check("refull_ready", 32'(bus.asi_ready), 32'd0);
    rd(2'd0, x);
    check("drain_data", x, 32'hF01);
    check("drain_ready", 32'(bus.asi_ready), 32'd1);

    // CLEAR during a RECV beat
    wr3(32'h2);
    beat(1, 0, 32'h1); beat(0, 0, 32'h2);
    step(1, 0, 0, 32'h3, 0, 1, 2'd3, 32'h2, x);
    rd(2'd2, x);
    check("clr_level", x, 32'd0);
    rd(2'd3, x);
    check("clr_drops", x, 32'd0);
    beat(0, 1, 32'h4);
    rd(2'd2, x);
    check("clr_ignored", x, 32'd0);

    // Reset mid-packet is not a drop
    beat(1, 0, 32'h5); beat(0, 0, 32'h6);
    do_reset();
    idle();
    rd(2'd3, x);
    check("rstmid_drops", x, 32'd0);
    rd(2'd2, x);
    check("rstmid_level", x, 32'd0);

    // Random traffic in phases: short packets, long packets, slow reader, mixed
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 800; c++) begin
        v = ($urandom_range(99) < 70);
        s = (ph == 1) ? ($urandom_range(999) < 4) : ($urandom_range(99) < 20);
        e = (ph == 1) ? ($urandom_range(999) < 3) : ($urandom_range(99) < 25);
        r = ($urandom_range(99) < ((ph == 2) ? 5 : (ph == 1 ? 15 : 40)));
        w = ($urandom_range(99) < 3);
        a = ($urandom_range(99) < 60) ? 2'd0 : 2'($urandom_range(3));
        if (w) a = ($urandom_range(99) < 70) ? 2'd3 : 2'($urandom_range(2));
        wd = ($urandom_range(99) < 8) ? 32'h2 : 32'($urandom_range(1));
        step(v, s, e, $urandom, r, w, a, wd, x);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
